// File: rtl/nios_sample_capture.sv
// nios_sample_capture: arms on start, waits for a trigger level, then packs
// 16-bit Avalon-ST samples into 32-bit on-chip RAM words. Two samples share
// one word address, and the byte enables select the low or the high half.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | nothing armed; sink not ready; no writes
//   WAIT_TRIG | armed; samples are consumed and discarded until trigger
//   CAPTURE   | every valid sample is written to RAM in the same cycle
//   DONE      | len samples stored; done stays high until the next start
`timescale 1ns/1ps

module nios_sample_capture #(
  parameter int DEPTH  = 37500,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              trigger,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  // The RAM holds two samples per word, so the longest capture is 2*DEPTH.
  localparam int              MAX_LEN_I = 2 * DEPTH;
  localparam logic [ADDR_W:0] MAX_LEN   = MAX_LEN_I[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   start_len;
  logic              capture_wr;

  assign start_len = (num_samples > MAX_LEN) ? MAX_LEN : num_samples;
  assign count_inc = sample_count + ONE;

  // State, length and sample counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      sample_count <= '0;
    end else begin
      state        <= state_nxt;
      len          <= len_nxt;
      sample_count <= count_nxt;
    end
  end

  // Next-state logic; abort outranks everything, start is only heard when not busy.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    count_nxt  = sample_count;
    capture_wr = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          len_nxt   = start_len;
          count_nxt = '0;
          state_nxt = (start_len == '0) ? DONE : WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (trigger) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (in_valid) begin
          capture_wr = 1'b1;
          count_nxt  = count_inc;
          if (count_inc == len) begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port is purely combinational so each sample lands in its own cycle;
  // idle values are zero so reset clears the bus as soon as the state clears.
  always_comb begin
    mem_chipselect = capture_wr;
    mem_write      = capture_wr;
    mem_address    = capture_wr ? sample_count[ADDR_W:1] : '0;
    mem_byteenable = capture_wr ? (sample_count[0] ? 4'b1100 : 4'b0011) : 4'b0000;
    mem_writedata  = capture_wr ? {in_data, in_data} : 32'h0;
    mem_clken      = 1'b1;
    busy           = (state == WAIT_TRIG) || (state == CAPTURE);
    in_ready       = (state == WAIT_TRIG) || (state == CAPTURE);
    done           = (state == DONE);
  end

endmodule

// File: tb/tb_nios_sample_capture.sv
// Testbench for nios_sample_capture: drives randomized sample streams and
// compares every RAM write against a queue of expected writes derived from
// the sample index (word = index/2, low half for even, high half for odd).
`timescale 1ns/1ps

module tb_nios_sample_capture;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 37500;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              trigger;
  logic [ADDR_W:0]   num_samples;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_count;

  int n_chk  = 0;
  int n_fail = 0;
  int ws_bad = 0;

  // Observed writes and expected writes: {address, byteenable, writedata}.
  logic [51:0] got_q[$];
  logic [51:0] exp_q[$];

  nios_sample_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
    .num_samples(num_samples), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
    .done(done), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Record every RAM write mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_write) got_q.push_back({mem_address, mem_byteenable, mem_writedata});
    if (mem_write && !mem_chipselect) ws_bad++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: sample number idx of a capture goes to word idx/2, half idx%2.
  function automatic logic [51:0] exp_write(input int idx, input logic [15:0] d);
    logic [15:0] a;
    logic [3:0]  be;
    a  = 16'(idx / 2);
    be = (idx % 2 == 1) ? 4'b1100 : 4'b0011;
    return {a, be, d, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = 17'(n);
    tick();
    start       = 1'b0;
  endtask

  task automatic do_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  // Offer n accepted samples with random gaps; record the writes they must cause.
  task automatic run_samples(input int n, input int gap_pct, input int base_idx);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < n * 20 + 100) begin
      in_data = 16'($urandom);
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        exp_q.push_back(exp_write(base_idx + sent, in_data));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (sent != n) begin
      n_fail++;
      $display("FAIL run_samples_budget sent %0d required %0d", sent, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; trigger = 0; num_samples = '0;
    in_data = '0; in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_port got cs=%b wr=%b addr=%h be=%b data=%h required all zero",
               mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    n_chk++;
    if ({busy, done, in_ready, sample_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_status got busy=%b done=%b ready=%b count=%0d required zero",
               busy, done, in_ready, sample_count);
    end
    n_chk++;
    if (mem_clken !== 1'b1) begin
      n_fail++;
      $display("FAIL clken got %b required 1", mem_clken);
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if ({busy, done, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset got busy=%b done=%b ready=%b required 000", busy, done, in_ready);
    end
  endtask

  task automatic test_zero_len();
    clear_q();
    start = 1'b1; num_samples = '0;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy_start got %b required 0", busy);
    end
    tick();
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got done=%b busy=%b required done=1 busy=0", done, busy);
    end
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      n_chk++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_idle got busy=%b ready=%b required 0 0", busy, in_ready);
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_writes got %0d required 0", got_q.size());
    end
  endtask

  task automatic test_basic();
    clear_q();
    do_start(4);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 17'd0) begin
      n_fail++;
      $display("FAIL basic_armed got busy=%b done=%b count=%0d required 1 0 0", busy, done, sample_count);
    end
    do_trigger();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(32'h1111 * (i + 1));
      exp_q.push_back(exp_write(i, in_data));
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 17'd4) begin
      n_fail++;
      $display("FAIL basic_done got done=%b busy=%b count=%0d required 1 0 4", done, busy, sample_count);
    end
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_write_count got %0d required 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_write[%0d] got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    start = 1'b1; trigger = 1'b1; num_samples = 17'd3;
    tick();
    start = 1'b0; trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      if (i == 1) begin
        start = 1'b1; num_samples = 17'd1;
      end
      #1;
      n_chk++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wait_trig_ready got ready=%b busy=%b required 1 1", in_ready, busy);
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    do_trigger();
    run_samples(3, 40, 0);
    n_chk++;
    if (done !== 1'b1 || sample_count !== 17'd3) begin
      n_fail++;
      $display("FAIL gaps_done got done=%b count=%0d required 1 3", done, sample_count);
    end
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 16'($urandom);
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL done_ready got %b required 0", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL gaps_write_count got %0d required 3", got_q.size());
    end else begin
      n_chk++;
      if (got_q[2][51:32] !== {16'd1, 4'b0011}) begin
        n_fail++;
        $display("FAIL gaps_last got addr/be %h required 00013", got_q[2][51:32]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gaps_write[%0d] got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    clear_q();
    do_start(10);
    do_trigger();
    run_samples(5, 0, 0);
    abort = 1'b1; start = 1'b1; num_samples = 17'd2;
    in_valid = 1'b1; in_data = 16'($urandom);
    tick();
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || sample_count !== 17'd5) begin
      n_fail++;
      $display("FAIL abort_idle got busy=%b done=%b ready=%b count=%0d required 0 0 0 5",
               busy, done, in_ready, sample_count);
    end
    n_chk++;
    if (got_q.size() != 5) begin
      n_fail++;
      $display("FAIL abort_write_count got %0d required 5", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_write[%0d] got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
    clear_q();
    do_start(2);
    do_trigger();
    run_samples(2, 30, 0);
    n_chk++;
    if (done !== 1'b1 || sample_count !== 17'd2 || got_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_restart got done=%b count=%0d writes=%0d required 1 2 2",
               done, sample_count, got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_write[%0d] got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int n;
      int stop_at;
      bit do_abort;
      clear_q();
      n        = int'($urandom_range(1, 12));
      do_abort = ($urandom_range(3) == 0);
      stop_at  = do_abort ? int'($urandom_range(0, n - 1)) : n;
      do_start(n);
      repeat ($urandom_range(0, 4)) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
        tick();
      end
      in_valid = 1'b0;
      do_trigger();
      run_samples(stop_at, 50, 0);
      if (do_abort) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      n_chk++;
      if (done !== !do_abort || busy !== 1'b0 || sample_count !== 17'(stop_at)) begin
        n_fail++;
        $display("FAIL random[%0d] got done=%b busy=%b count=%0d required done=%b busy=0 count=%0d",
                 it, done, busy, sample_count, !do_abort, stop_at);
      end
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL random_count[%0d] got %0d required %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_write[%0d][%0d] got %h required %h", it, i,
                   (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int errs = 0;
    clear_q();
    do_start(80000);
    do_trigger();
    run_samples(2 * DEPTH, 0, 0);
    n_chk++;
    if (done !== 1'b1 || sample_count !== 17'(2 * DEPTH)) begin
      n_fail++;
      $display("FAIL clamp_done got done=%b count=%0d required 1 %0d", done, sample_count, 2 * DEPTH);
    end
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    n_chk++;
    if (got_q.size() != 2 * DEPTH) begin
      n_fail++;
      $display("FAIL clamp_write_count got %0d required %0d", got_q.size(), 2 * DEPTH);
    end else begin
      n_chk++;
      if (got_q[2 * DEPTH - 1][51:32] !== {16'(DEPTH - 1), 4'b1100}) begin
        n_fail++;
        $display("FAIL clamp_last got addr/be %h required %h", got_q[2 * DEPTH - 1][51:32],
                 {16'(DEPTH - 1), 4'b1100});
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL clamp_write[%0d] got %h required %h", i,
                   (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    do_start(10);
    do_trigger();
    run_samples(3, 0, 0);
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata} !== '0) begin
      n_fail++;
      $display("FAIL midreset_mem_port got cs=%b wr=%b addr=%h be=%b data=%h required all zero",
               mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    n_chk++;
    if ({busy, done, in_ready, sample_count} !== '0) begin
      n_fail++;
      $display("FAIL midreset_status got busy=%b done=%b ready=%b count=%0d required zero",
               busy, done, in_ready, sample_count);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if ({busy, done, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_idle got busy=%b done=%b ready=%b required 000", busy, done, in_ready);
    end
    n_chk++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL midreset_write_count got %0d required 3", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_write[%0d] got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 52'h0, exp_q[i]);
      end
    end
    n_chk++;
    if (ws_bad != 0) begin
      n_fail++;
      $display("FAIL write_without_cs got %0d cycles required 0", ws_bad);
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic();
    test_gaps();
    test_abort();
    test_random();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
